// File: rtl/magia_tile_axi_mem_sink.sv
// magia_tile_axi_mem_sink
// Purpose: AXI4 subordinate memory sitting downstream of the tile's data_out port.
//          Serves INCR/FIXED bursts from a local word array with a configurable read
//          latency, answers DECERR for unmapped beats and SLVERR for WRAP bursts or
//          w.last/len disagreement. One write and one read in flight, independently.
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   axi_req_i  AW/W/AR payload + valid, b_ready, r_ready
//   axi_rsp_o  aw/w/ar_ready, B and R payload + valid
//   err_cnt_o  saturating count of non-OKAY B responses and R beats

// Local stand-in for the tile's AXI typedefs so this memory builds on its own.
package magia_pkg;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ax_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_ax_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ax_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_default_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_default_rsp_t;
endpackage

module magia_tile_axi_mem_sink
    import magia_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned READ_LAT  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  axi_default_req_t axi_req_i,
    output axi_default_rsp_t axi_rsp_o,
    output logic [15:0]      err_cnt_o
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned OFF_BITS = $clog2(STRB_W);
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rState_e;

    function automatic logic inRange(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> OFF_BITS) < MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] wordIdx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE_ADDR) >> OFF_BITS;
        return IDX_W'(off);
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    wState_e          r_wState, w_wNext;
    logic [3:0]       r_wId;
    logic [31:0]      r_wAddr;
    logic [7:0]       r_wLen, r_wBeat;
    logic [2:0]       r_wSize;
    logic [1:0]       r_wBurst;
    logic             r_wDecErr, r_wSlvErr;

    rState_e          r_rState, w_rNext;
    logic [3:0]       r_rId;
    logic [31:0]      r_rAddr;
    logic [7:0]       r_rLen, r_rBeat, r_rLat;
    logic [2:0]       r_rSize;
    logic [1:0]       r_rBurst;
    logic [DATA_W-1:0] r_rData;
    logic [1:0]       r_rResp;
    logic [15:0]      r_errCnt;

    logic             w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;
    logic             w_wLastBeat, w_wIsWrap, w_wInRange, w_memWe, w_rLastBeat;
    logic [31:0]      w_wStep, w_rStep, w_rLookAddr;
    logic [1:0]       w_rLookBurst, w_bResp, w_rLookResp;
    logic [DATA_W-1:0] w_rLookData;
    logic             w_rLoad;
    logic [1:0]       w_errInc;
    logic [16:0]      w_errSum;

    assign w_awHs      = (r_wState == W_IDLE) && axi_req_i.aw_valid;
    assign w_wHs       = (r_wState == W_DATA) && axi_req_i.w_valid;
    assign w_bHs       = (r_wState == W_RESP) && axi_req_i.b_ready;
    assign w_arHs      = (r_rState == R_IDLE) && axi_req_i.ar_valid;
    assign w_rHs       = (r_rState == R_DATA) && axi_req_i.r_ready;
    assign w_wLastBeat = (r_wBeat == r_wLen);
    assign w_rLastBeat = (r_rBeat == r_rLen);
    assign w_wIsWrap   = (r_wBurst == AXI_BURST_WRAP);
    assign w_wInRange  = inRange(r_wAddr);
    assign w_wStep     = (r_wBurst == AXI_BURST_INCR) ? (32'd1 << r_wSize) : 32'd0;
    assign w_rStep     = (r_rBurst == AXI_BURST_INCR) ? (32'd1 << r_rSize) : 32'd0;
    assign w_memWe     = w_wHs && !w_wIsWrap && w_wInRange && !rst_i;
    assign w_bResp     = r_wDecErr ? AXI_RESP_DECERR :
                         r_wSlvErr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

    // Both FSM state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wState <= W_IDLE;
            r_rState <= R_IDLE;
        end else begin
            r_wState <= w_wNext;
            r_rState <= w_rNext;
        end
    end

    // Write FSM: the burst ends on the beat counter, never on w.last alone.
    always_comb begin
        w_wNext = r_wState;
        case (r_wState)
            W_IDLE:  if (axi_req_i.aw_valid) w_wNext = W_DATA;
            W_DATA:  if (w_wHs && w_wLastBeat) w_wNext = W_RESP;
            W_RESP:  if (axi_req_i.b_ready) w_wNext = W_IDLE;
            default: w_wNext = W_IDLE;
        endcase
    end

    // Read FSM: the latency counter reaches zero on the same edge that enters
    // R_DATA, so the first r_valid lands READ_LAT cycles after the AR handshake.
    always_comb begin
        w_rNext = r_rState;
        case (r_rState)
            R_IDLE:  if (axi_req_i.ar_valid) w_rNext = (READ_LAT <= 1) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_rLat <= 8'd1) w_rNext = R_DATA;
            R_DATA:  if (w_rHs && w_rLastBeat) w_rNext = R_IDLE;
            default: w_rNext = R_IDLE;
        endcase
    end

    // Beat about to be presented on R: the AR address when latency is one cycle,
    // the next burst address while streaming, otherwise the latched address.
    always_comb begin
        w_rLookAddr  = r_rAddr;
        w_rLookBurst = r_rBurst;
        if (r_rState == R_IDLE) begin
            w_rLookAddr  = axi_req_i.ar.addr;
            w_rLookBurst = axi_req_i.ar.burst;
        end else if (r_rState == R_DATA) begin
            w_rLookAddr = r_rAddr + w_rStep;
        end
        w_rLookData = '0;
        w_rLookResp = AXI_RESP_OKAY;
        if (w_rLookBurst == AXI_BURST_WRAP) begin
            w_rLookResp = AXI_RESP_SLVERR;
        end else if (inRange(w_rLookAddr)) begin
            w_rLookData = r_mem[wordIdx(w_rLookAddr)];
        end else begin
            w_rLookResp = AXI_RESP_DECERR;
        end
        w_rLoad = (w_rNext == R_DATA) && ((r_rState != R_DATA) || w_rHs);
    end

    // Read data is registered one edge ahead so it stays put during a stall,
    // and a same-edge write to that word is seen only by later beats.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wId <= '0; r_wAddr <= '0; r_wLen <= '0; r_wSize <= '0; r_wBurst <= '0;
            r_wBeat <= '0; r_wDecErr <= 1'b0; r_wSlvErr <= 1'b0;
            r_rId <= '0; r_rAddr <= '0; r_rLen <= '0; r_rSize <= '0; r_rBurst <= '0;
            r_rBeat <= '0; r_rLat <= '0; r_rData <= '0; r_rResp <= '0;
            r_errCnt <= '0;
        end else begin
            if (w_awHs) begin
                r_wId     <= axi_req_i.aw.id;
                r_wAddr   <= axi_req_i.aw.addr;
                r_wLen    <= axi_req_i.aw.len;
                r_wSize   <= axi_req_i.aw.size;
                r_wBurst  <= axi_req_i.aw.burst;
                r_wBeat   <= '0;
                r_wDecErr <= 1'b0;
                r_wSlvErr <= 1'b0;
            end else if (w_wHs) begin
                r_wBeat   <= r_wBeat + 8'd1;
                r_wAddr   <= r_wAddr + w_wStep;
                r_wDecErr <= r_wDecErr || (!w_wIsWrap && !w_wInRange);
                r_wSlvErr <= r_wSlvErr || w_wIsWrap || (w_wLastBeat != axi_req_i.w.last);
            end
            if (w_arHs) begin
                r_rId    <= axi_req_i.ar.id;
                r_rAddr  <= axi_req_i.ar.addr;
                r_rLen   <= axi_req_i.ar.len;
                r_rSize  <= axi_req_i.ar.size;
                r_rBurst <= axi_req_i.ar.burst;
                r_rBeat  <= '0;
                r_rLat   <= 8'(READ_LAT - 1);
            end else if (r_rState == R_WAIT) begin
                r_rLat <= r_rLat - 8'd1;
            end else if (w_rHs) begin
                r_rBeat <= r_rBeat + 8'd1;
                r_rAddr <= r_rAddr + w_rStep;
            end
            if (w_rLoad) begin
                r_rData <= w_rLookData;
                r_rResp <= w_rLookResp;
            end
            r_errCnt <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
        end
    end

    assign w_errInc = {1'b0, w_bHs && (w_bResp != AXI_RESP_OKAY)} +
                      {1'b0, w_rHs && (r_rResp != AXI_RESP_OKAY)};
    assign w_errSum = {1'b0, r_errCnt} + {15'd0, w_errInc};

    // Byte-lane writes; the array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (w_memWe) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_req_i.w.strb[b]) r_mem[wordIdx(r_wAddr)][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
    end

    // Readies are forced low while reset is held.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = (r_wState == W_IDLE) && !rst_i;
        axi_rsp_o.w_ready  = (r_wState == W_DATA) && !rst_i;
        axi_rsp_o.b_valid  = (r_wState == W_RESP);
        axi_rsp_o.b.id     = r_wId;
        axi_rsp_o.b.resp   = w_bResp;
        axi_rsp_o.ar_ready = (r_rState == R_IDLE) && !rst_i;
        axi_rsp_o.r_valid  = (r_rState == R_DATA);
        axi_rsp_o.r.id     = r_rId;
        axi_rsp_o.r.data   = r_rData;
        axi_rsp_o.r.resp   = r_rResp;
        axi_rsp_o.r.last   = (r_rState == R_DATA) && w_rLastBeat;
    end

    assign err_cnt_o = r_errCnt;

endmodule
